ras_ckpt_stack: RTL and testbench

- Parametrised return-address stack (RAS) for the CVA6 frontend. Successor to the fixed, depth-configured RAS.
- Adds three features:
  - any depth, including non-power-of-two, with circular overwrite on overflow;
  - single-cycle call+return replace;
  - one speculative checkpoint/restore slot, so mispredict recovery restores the pointer and count.
- Sits between branch decode (push on call, pop on return) and the controller (flush, mispredict restore).

---
 rtl/ras_ckpt_stack.sv | 108 ++++++++++
 tb/tb_ras_ckpt_stack.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ras_ckpt_stack.sv
// Return-address stack with any-depth circular storage, call+return replace,
// and a single speculative checkpoint of {tos, count} for mispredict recovery.
module ras_ckpt_stack #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned VLEN  = 64,
    parameter int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [VLEN-1:0]  push_addr_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic             ckpt_save_i,
    input  logic             ckpt_restore_i,
    output logic [VLEN-1:0]  top_addr_o,
    output logic             top_valid_o,
    output logic [PTR_W:0]   count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam int unsigned     CW   = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CW-1:0]    FULL = CW'(DEPTH);

    logic [VLEN-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] tos_q, tos_n, ckpt_tos_q, wr_idx;
    logic [CW-1:0]    count_q, count_n, ckpt_count_q;
    logic             overflow_q, overflow_n, underflow_q, underflow_n, wr_en;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] x);
        return (x == LAST) ? '0 : x + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] dec(input logic [PTR_W-1:0] x);
        return (x == '0) ? LAST : x - PTR_W'(1);
    endfunction

    always_comb begin
        tos_n       = tos_q;
        count_n     = count_q;
        wr_en       = 1'b0;
        wr_idx      = tos_q;
        overflow_n  = 1'b0;
        underflow_n = 1'b0;
        if (flush_i) begin
            tos_n   = '0;
            count_n = '0;
        end else if (ckpt_restore_i) begin
            tos_n   = ckpt_tos_q;
            count_n = ckpt_count_q;
        end else if (push_i && pop_i && count_q != '0) begin
            wr_en = 1'b1;
        end else if (push_i) begin
            tos_n  = inc(tos_q);
            wr_idx = inc(tos_q);
            wr_en  = 1'b1;
            if (count_q == FULL) begin
                overflow_n = 1'b1;
            end else begin
                count_n = count_q + CW'(1);
            end
        end else if (pop_i) begin
            if (count_q != '0) begin
                tos_n   = dec(tos_q);
                count_n = count_q - CW'(1);
            end else begin
                underflow_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tos_q        <= '0;
            count_q      <= '0;
            ckpt_tos_q   <= '0;
            ckpt_count_q <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            tos_q       <= tos_n;
            count_q     <= count_n;
            overflow_q  <= overflow_n;
            underflow_q <= underflow_n;
            if (wr_en) begin
                mem[wr_idx] <= push_addr_i;
            end
            // Checkpoint takes the post-update state, so it follows flush/restore.
            if (ckpt_save_i) begin
                ckpt_tos_q   <= tos_n;
                ckpt_count_q <= count_n;
            end
        end
    end

    assign top_addr_o  = mem[tos_q];
    assign top_valid_o = (count_q != '0);
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_ras_ckpt_stack.sv
// Drives DEPTH=1, 2 and 3 stacks with identical directed and random stimulus
// and compares every output against a modulo-arithmetic circular-buffer model.
module tb_ras_ckpt_stack;

    localparam logic [63:0] A = 64'h8000_0010;
    localparam logic [63:0] B = 64'h8000_0020;
    localparam logic [63:0] C = 64'h8000_0030;

    logic        clk = 1'b0;
    logic        rst, push, pop, flush, save, restore;
    logic [63:0] addr;

    logic [63:0] u1_top, u2_top, u3_top;
    logic        u1_val, u2_val, u3_val;
    logic [1:0]  u1_cnt, u2_cnt;
    logic [2:0]  u3_cnt;
    logic        u1_ovf, u2_ovf, u3_ovf, u1_unf, u2_unf, u3_unf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ras_ckpt_stack #(.DEPTH(1), .VLEN(64)) u1 (
        .clk_i(clk), .rst_i(rst), .push_i(push), .push_addr_i(addr), .pop_i(pop),
        .flush_i(flush), .ckpt_save_i(save), .ckpt_restore_i(restore),
        .top_addr_o(u1_top), .top_valid_o(u1_val), .count_o(u1_cnt),
        .overflow_o(u1_ovf), .underflow_o(u1_unf));

    ras_ckpt_stack #(.DEPTH(2), .VLEN(64)) u2 (
        .clk_i(clk), .rst_i(rst), .push_i(push), .push_addr_i(addr), .pop_i(pop),
        .flush_i(flush), .ckpt_save_i(save), .ckpt_restore_i(restore),
        .top_addr_o(u2_top), .top_valid_o(u2_val), .count_o(u2_cnt),
        .overflow_o(u2_ovf), .underflow_o(u2_unf));

    ras_ckpt_stack #(.DEPTH(3), .VLEN(64)) u3 (
        .clk_i(clk), .rst_i(rst), .push_i(push), .push_addr_i(addr), .pop_i(pop),
        .flush_i(flush), .ckpt_save_i(save), .ckpt_restore_i(restore),
        .top_addr_o(u3_top), .top_valid_o(u3_val), .count_o(u3_cnt),
        .overflow_o(u3_ovf), .underflow_o(u3_unf));

    int          dep [3] = '{1, 2, 3};
    logic [63:0] m_mem [3][64];
    int          m_tos [3], m_cnt [3], m_ctos [3], m_ccnt [3];
    bit          m_ovf [3], m_unf [3];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int d = dep[k];
        if (rst) begin
            for (int i = 0; i < 64; i++) m_mem[k][i] = '0;
            m_tos[k] = 0; m_cnt[k] = 0; m_ctos[k] = 0; m_ccnt[k] = 0;
            m_ovf[k] = 0; m_unf[k] = 0;
            return;
        end
        m_ovf[k] = 0;
        m_unf[k] = 0;
        if (flush) begin
            m_tos[k] = 0; m_cnt[k] = 0;
        end else if (restore) begin
            m_tos[k] = m_ctos[k]; m_cnt[k] = m_ccnt[k];
        end else if (push && pop && m_cnt[k] > 0) begin
            m_mem[k][m_tos[k]] = addr;
        end else if (push) begin
            m_tos[k] = (m_tos[k] + 1) % d;
            m_mem[k][m_tos[k]] = addr;
            if (m_cnt[k] == d) m_ovf[k] = 1;
            else m_cnt[k]++;
        end else if (pop) begin
            if (m_cnt[k] > 0) begin
                m_tos[k] = (m_tos[k] + d - 1) % d;
                m_cnt[k]--;
            end else begin
                m_unf[k] = 1;
            end
        end
        if (save) begin
            m_ctos[k] = m_tos[k]; m_ccnt[k] = m_cnt[k];
        end
    endtask

    task automatic check_inst(input int k);
        logic [63:0] top, cnt;
        logic        val, ovf, unf;
        case (k)
            0: begin top = u1_top; val = u1_val; cnt = 64'(u1_cnt); ovf = u1_ovf; unf = u1_unf; end
            1: begin top = u2_top; val = u2_val; cnt = 64'(u2_cnt); ovf = u2_ovf; unf = u2_unf; end
            default: begin top = u3_top; val = u3_val; cnt = 64'(u3_cnt); ovf = u3_ovf; unf = u3_unf; end
        endcase
        chk($sformatf("d%0d_top", dep[k]), top, m_mem[k][m_tos[k]]);
        chk($sformatf("d%0d_valid", dep[k]), 64'(val), 64'(m_cnt[k] != 0));
        chk($sformatf("d%0d_count", dep[k]), cnt, 64'(m_cnt[k]));
        chk($sformatf("d%0d_overflow", dep[k]), 64'(ovf), 64'(m_ovf[k]));
        chk($sformatf("d%0d_underflow", dep[k]), 64'(unf), 64'(m_unf[k]));
    endtask

    task automatic cycle(input bit r, input bit p, input logic [63:0] a, input bit po,
                         input bit f, input bit s, input bit rs);
        rst = r; push = p; addr = a; pop = po; flush = f; save = s; restore = rs;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k);
        #1;
        for (int k = 0; k < 3; k++) check_inst(k);
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0;
        save = 1'b0; restore = 1'b0; addr = '0;

        // reset state
        cycle(1, 0, 0, 0, 0, 0, 0);
        chk("rst_count", 64'(u2_cnt), 0);
        chk("rst_top", u2_top, 0);

        // basic push/pop
        cycle(0, 1, A, 0, 0, 0, 0);
        cycle(0, 1, B, 0, 0, 0, 0);
        chk("basic_top_b", u2_top, B);
        chk("basic_cnt2", 64'(u2_cnt), 2);
        cycle(0, 0, 0, 1, 0, 0, 0);
        chk("basic_top_a", u2_top, A);
        cycle(0, 0, 0, 1, 0, 0, 0);
        chk("basic_empty", 64'(u2_val), 0);

        // overflow on DEPTH=2
        cycle(0, 1, A, 0, 0, 0, 0);
        cycle(0, 1, B, 0, 0, 0, 0);
        cycle(0, 1, C, 0, 0, 0, 0);
        chk("ovf_pulse", 64'(u2_ovf), 1);
        chk("ovf_top_c", u2_top, C);
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("ovf_clear", 64'(u2_ovf), 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        chk("ovf_top_b", u2_top, B);
        cycle(0, 0, 0, 1, 0, 0, 0);
        chk("ovf_a_lost", 64'(u2_val), 0);

        // underflow and simultaneous push+pop
        cycle(0, 0, 0, 1, 0, 0, 0);
        chk("unf_pulse", 64'(u2_unf), 1);
        cycle(0, 1, A, 1, 0, 0, 0);
        chk("pp_empty_top", u2_top, A);
        chk("pp_empty_unf", 64'(u2_unf), 0);
        cycle(0, 1, B, 1, 0, 0, 0);
        chk("pp_replace_top", u2_top, B);
        chk("pp_replace_cnt", 64'(u2_cnt), 1);

        // checkpoint on DEPTH=3: overwritten slot is not recovered
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 1, A, 0, 0, 0, 0);
        cycle(0, 1, B, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 1, C, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("ckpt_cnt", 64'(u3_cnt), 2);
        chk("ckpt_top_c", u3_top, C);
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 1, C, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1);

        // priority: flush beats restore and push; restore beats push
        cycle(0, 1, A, 0, 0, 0, 0);
        cycle(0, 1, B, 0, 0, 0, 0);
        cycle(0, 1, C, 1, 1, 0, 1);
        chk("prio_flush_cnt", 64'(u3_cnt), 0);
        chk("prio_flush_ovf", 64'(u1_ovf), 0);
        cycle(0, 1, A, 0, 0, 1, 0);
        cycle(0, 1, B, 0, 0, 0, 1);
        chk("prio_restore_cnt", 64'(u3_cnt), 1);
        chk("prio_restore_top", u3_top, A);

        // reset mid-stream with a push, then restore the cleared checkpoint
        cycle(0, 1, A, 0, 0, 1, 0);
        cycle(0, 1, B, 0, 0, 1, 0);
        cycle(0, 1, C, 0, 0, 1, 0);
        cycle(1, 1, A, 0, 0, 0, 0);
        chk("midrst_top", u3_top, 0);
        chk("midrst_cnt", 64'(u3_cnt), 0);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("midrst_ckpt_cnt", 64'(u3_cnt), 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) < 5,
                  {$urandom, $urandom},
                  $urandom_range(0, 9) < 4,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 19) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
